// File: rtl/bmu_pipe_pkg.sv
// Shared opcode definitions for the pipelined bit-manipulation unit.
package bmu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_CLZ  = 4'd0,
    OP_CTZ  = 4'd1,
    OP_CPOP = 4'd2,
    OP_ROL  = 4'd3,
    OP_ROR  = 4'd4,
    OP_BSET = 4'd5,
    OP_BCLR = 4'd6,
    OP_BINV = 4'd7,
    OP_BEXT = 4'd8,
    OP_ANDN = 4'd9,
    OP_ORN  = 4'd10,
    OP_XNOR = 4'd11
  } bmu_op_e;

  localparam logic [3:0] BMU_OP_ILLEGAL_MIN = 4'd12;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op >= BMU_OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/bmu_alu_comb.sv
// Purely combinational BMU compute: op decode, counts, rotates, bit ops and CSR bypass.
module bmu_alu_comb
  import bmu_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [3:0]       op,
  input  logic             csr_ren,
  input  logic [WIDTH-1:0] csr_rddata,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  localparam int PAD = WIDTH - SHAMT_W - 1;
  localparam logic [SHAMT_W:0] CNT_ONE   = (SHAMT_W + 1)'(1);
  localparam logic [SHAMT_W:0] WIDTH_CNT = (SHAMT_W + 1)'(WIDTH);

  logic [SHAMT_W-1:0] shamt;
  logic [SHAMT_W:0]   rot_back;
  logic [SHAMT_W:0]   lz_cnt;
  logic [SHAMT_W:0]   tz_cnt;
  logic [SHAMT_W:0]   pop_cnt;
  logic               lz_done;
  logic               tz_done;
  logic [WIDTH-1:0]   bit_mask;

  assign shamt    = b[SHAMT_W-1:0];
  assign rot_back = WIDTH_CNT - {1'b0, shamt};
  assign bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << shamt;

  // Counts need one extra bit so that A=0 can report the full WIDTH.
  always_comb begin
    lz_cnt  = '0;
    tz_cnt  = '0;
    pop_cnt = '0;
    lz_done = 1'b0;
    tz_done = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (a[i]) lz_done = 1'b1;
      else if (!lz_done) lz_cnt = lz_cnt + CNT_ONE;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) tz_done = 1'b1;
      else if (!tz_done) tz_cnt = tz_cnt + CNT_ONE;
      pop_cnt = pop_cnt + {{SHAMT_W{1'b0}}, a[i]};
    end
  end

  always_comb begin
    result = '0;
    error  = 1'b0;
    if (csr_ren) begin
      result = csr_rddata;
    end else if (op_is_illegal(op)) begin
      error = 1'b1;
    end else begin
      case (bmu_op_e'(op))
        OP_CLZ:  result = {{PAD{1'b0}}, lz_cnt};
        OP_CTZ:  result = {{PAD{1'b0}}, tz_cnt};
        OP_CPOP: result = {{PAD{1'b0}}, pop_cnt};
        OP_ROL:  result = (a << shamt) | (a >> rot_back);
        OP_ROR:  result = (a >> shamt) | (a << rot_back);
        OP_BSET: result = a | bit_mask;
        OP_BCLR: result = a & ~bit_mask;
        OP_BINV: result = a ^ bit_mask;
        OP_BEXT: result = {{(WIDTH-1){1'b0}}, a[shamt]};
        OP_ANDN: result = a & ~b;
        OP_ORN:  result = a | ~b;
        OP_XNOR: result = ~(a ^ b);
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/bmu_pipe.sv
// Pipelined BMU with valid/ready handshake; whole pipeline stalls on backpressure.
// Optional performance counters enabled by defining BMU_PIPE_PERF_CNT_EN.
module bmu_pipe
  import bmu_pipe_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int SHAMT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_csr_ren,
  input  logic [WIDTH-1:0] in_csr_rddata,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_error
`ifdef BMU_PIPE_PERF_CNT_EN
  ,
  output logic [31:0]      perf_ops_cnt,
  output logic [31:0]      perf_err_cnt
`endif
);

  localparam int LAST = PIPE_STAGES - 1;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             error;
  } bmu_stage_t;

  bmu_stage_t       stages [PIPE_STAGES];
  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] alu_result;
  logic             alu_error;

  bmu_alu_comb #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_alu (
    .op         (in_op),
    .csr_ren    (in_csr_ren),
    .csr_rddata (in_csr_rddata),
    .a          (in_a),
    .b          (in_b),
    .result     (alu_result),
    .error      (alu_error)
  );

  assign out_valid = stages[LAST].valid;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && in_ready;

  // All stages move together or hold together; bubbles are kept, not squeezed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_STAGES; i++) stages[i] <= '0;
    end else if (advance) begin
      stages[0] <= bmu_stage_t'{valid: accept, result: alu_result, error: alu_error};
      for (int i = 1; i < PIPE_STAGES; i++) stages[i] <= stages[i-1];
    end
  end

  assign out_result = out_valid ? stages[LAST].result : '0;
  assign out_error  = out_valid ? stages[LAST].error  : 1'b0;

`ifdef BMU_PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_cnt <= '0;
      perf_err_cnt <= '0;
    end else if (out_valid && out_ready) begin
      perf_ops_cnt <= perf_ops_cnt + 32'd1;
      if (out_error) perf_err_cnt <= perf_err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bmu_pipe.sv
// Directed scoreboard testbench for bmu_pipe (WIDTH=32, PIPE_STAGES=2).
module tb_bmu_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic        in_csr_ren;
  logic [31:0] in_csr_rddata;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_error;
`ifdef BMU_PIPE_PERF_CNT_EN
  logic [31:0] perf_ops_cnt;
  logic [31:0] perf_err_cnt;
  int          tb_ops;
  int          tb_errs;
`endif

  bmu_pipe #(
    .WIDTH       (32),
    .PIPE_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_csr_ren    (in_csr_ren),
    .in_csr_rddata (in_csr_rddata),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_error     (out_error)
`ifdef BMU_PIPE_PERF_CNT_EN
    ,
    .perf_ops_cnt  (perf_ops_cnt),
    .perf_err_cnt  (perf_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic        error;
    int          acc_cyc;
    bit          chk_lat;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int          tests_run;
  int          tests_failed;
  int          cyc;
  int          bp_left;
  bit          bp_armed;
  bit          bp_mode;
  bit          accepted;
  logic [31:0] pend_result;
  logic        pend_error;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: settle, check stall/output, record acceptance, step the edge.
  task automatic cycle();
    sb_entry_t e;
    if (bp_armed && out_valid) begin
      out_ready = 1'b0;
      bp_left   = 3;
      bp_armed  = 1'b0;
    end
    #1;
    if (bp_left > 0) begin
      checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("stall_out_valid", {31'b0, out_valid}, 32'd1);
      if (sb.size() > 0) begin
        checkOutput("stall_hold_result", out_result, sb[0].result);
        checkOutput("stall_hold_error", {31'b0, out_error}, {31'b0, sb[0].error});
      end
      bp_left--;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_output", {31'b0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("result", out_result, e.result);
        checkOutput("error", {31'b0, out_error}, {31'b0, e.error});
        if (e.chk_lat) checkOutput("latency", 32'(cyc - e.acc_cyc), 32'd2);
`ifdef BMU_PIPE_PERF_CNT_EN
        tb_ops++;
        if (e.error) tb_errs++;
`endif
      end
    end else if (!out_valid) begin
      checkOutput("idle_result_zero", out_result, 32'd0);
      checkOutput("idle_error_zero", {31'b0, out_error}, 32'd0);
    end
    if (in_valid && in_ready) begin
      e.result  = pend_result;
      e.error   = pend_error;
      e.acc_cyc = cyc;
      e.chk_lat = !bp_mode;
      sb.push_back(e);
      accepted  = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bp_left == 0) out_ready = 1'b1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic csr, input logic [31:0] rd,
                               input logic [31:0] exp_r, input logic exp_e);
    in_valid      = 1'b1;
    in_op         = op;
    in_a          = a;
    in_b          = b;
    in_csr_ren    = csr;
    in_csr_rddata = rd;
    pend_result   = exp_r;
    pend_error    = exp_e;
    accepted      = 1'b0;
    for (int n = 0; n < 20 && !accepted; n++) cycle();
    checkOutput("accept_timeout", {31'b0, accepted}, 32'd1);
    in_valid   = 1'b0;
    in_csr_ren = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && sb.size() > 0; n++) cycle();
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; cyc = 0; bp_left = 0;
    bp_armed = 1'b0; bp_mode = 1'b0; accepted = 1'b0;
    pend_result = '0; pend_error = 1'b0;
`ifdef BMU_PIPE_PERF_CNT_EN
    tb_ops = 0; tb_errs = 0;
`endif
    rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_csr_ren = 1'b0;
    in_csr_rddata = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out_result", out_result, 32'd0);
    checkOutput("reset_out_error", {31'b0, out_error}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);

    applyStimulus(4'd0, 32'h0000_0000, 32'h0, 1'b0, 32'h0, 32'd32, 1'b0);
    applyStimulus(4'd0, 32'h0001_0000, 32'h0, 1'b0, 32'h0, 32'd15, 1'b0);
    applyStimulus(4'd2, 32'hF0F0_0001, 32'h0, 1'b0, 32'h0, 32'd9, 1'b0);
    drain();
    applyStimulus(4'd3, 32'h8000_0001, 32'h0000_0021, 1'b0, 32'h0, 32'h0000_0003, 1'b0);
    applyStimulus(4'd7, 32'h0000_0000, 32'd31, 1'b0, 32'h0, 32'h8000_0000, 1'b0);
    drain();
    applyStimulus(4'd12, 32'h0000_1234, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    applyStimulus(4'd9, 32'h0000_FF00, 32'h0000_0F00, 1'b0, 32'h0, 32'h0000_F000, 1'b0);
    applyStimulus(4'd13, 32'h1111_1111, 32'h2222_2222, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(4'd10, 32'h0000_00F0, 32'hFFFF_FF0F, 1'b0, 32'h0, 32'h0000_00F0, 1'b0);
    applyStimulus(4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 1'b0, 32'h0, 32'hFFFF_FFFE, 1'b0);
    drain();
`ifdef BMU_PIPE_PERF_CNT_EN
    checkOutput("perf_ops", perf_ops_cnt, 32'(tb_ops));
    checkOutput("perf_errs", perf_err_cnt, 32'(tb_errs));
`endif

    bp_mode  = 1'b1;
    bp_armed = 1'b1;
    applyStimulus(4'd1, 32'h0000_0100, 32'h0, 1'b0, 32'h0, 32'd8, 1'b0);
    applyStimulus(4'd4, 32'h0000_0003, 32'h0000_0001, 1'b0, 32'h0, 32'h8000_0001, 1'b0);
    applyStimulus(4'd5, 32'h0000_0000, 32'h0000_0045, 1'b0, 32'h0, 32'h0000_0020, 1'b0);
    applyStimulus(4'd8, 32'h0000_0080, 32'h0000_0007, 1'b0, 32'h0, 32'h0000_0001, 1'b0);
    applyStimulus(4'd11, 32'hFFFF_0000, 32'hFF00_FF00, 1'b0, 32'h0, 32'hFF00_00FF, 1'b0);
    drain();
    bp_mode = 1'b0;

    applyStimulus(4'd2, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, 32'd32, 1'b0);
    applyStimulus(4'd0, 32'h0000_0001, 32'h0, 1'b0, 32'h0, 32'd31, 1'b0);
    rst       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst       = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midreset_out_result", out_result, 32'd0);
    checkOutput("midreset_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef BMU_PIPE_PERF_CNT_EN
    checkOutput("midreset_perf_ops", perf_ops_cnt, 32'd0);
    checkOutput("midreset_perf_errs", perf_err_cnt, 32'd0);
`endif
    for (int n = 0; n < 6; n++) cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bmu_pipe.md
Name: bmu_pipe

Overview:
- Parametrised, pipelined successor of the single-cycle bit-manipulation unit (BMU).
- WIDTH-bit bit-manipulation datapath with a valid/ready handshake on both sides.
- Latency is PIPE_STAGES cycles; the whole pipeline stalls under downstream backpressure.
- Sits between the decode/issue stage and writeback; also carries the CSR-read bypass path.

Parameters:
- WIDTH, 32, datapath width; power of 2, minimum 8.
- PIPE_STAGES, 2, register stages from input to output; minimum 1.
- SHAMT_W, $clog2(WIDTH), derived; shift/bit-index width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  pipeline can accept a request this cycle
- in_op  input  4  opcode (encoding under Behaviour)
- in_csr_ren  input  1  CSR read bypass select
- in_csr_rddata  input  WIDTH  CSR read data
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B; low SHAMT_W bits used as shift amount / bit index
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  result
- out_error  output  1  illegal opcode flag, qualified by out_valid

Behaviour:
- Reset values: all stage valid bits 0, out_valid 0, out_result 0, out_error 0, in_ready 1 in the cycle after reset.
- In-flight entries are dropped on reset, including reset mid-operation.
- Advance condition: advance = !out_valid || out_ready; in_ready = advance (combinational).
- Acceptance: a request is accepted when in_valid && in_ready.
- Stage movement: when advance=1, every stage shifts forward and stage 0 loads {in_valid && in_ready, computed result, error}; when advance=0, all stages hold.
- Bubbles are not squeezed; a stalled pipeline holds its bubbles.
- Latency: a request accepted at cycle t gives out_valid at t+PIPE_STAGES when no stall occurs; each stall cycle adds one cycle.
- Order is preserved; no result is lost or duplicated.
- Computation is combinational ahead of the stage-0 register; later stages only delay.
- Opcodes:
  - 0 CLZ: count of leading zeros in A; A=0 gives WIDTH.
  - 1 CTZ: count of trailing zeros in A; A=0 gives WIDTH.
  - 2 CPOP: population count of A.
  - 3 ROL / 4 ROR: rotate A by b[SHAMT_W-1:0].
  - 5 BSET / 6 BCLR / 7 BINV: set / clear / invert bit b[SHAMT_W-1:0] of A.
  - 8 BEXT: bit b[SHAMT_W-1:0] of A, zero-extended.
  - 9 ANDN: A & ~B. 10 ORN: A | ~B. 11 XNOR: ~(A ^ B).
  - 12-15: illegal; result 0, error 1.
- Count results are zero-extended to WIDTH. Upper bits of B above SHAMT_W are ignored for shifts and bit-index ops.
- CSR bypass: in_csr_ren=1 takes priority over in_op. Result = in_csr_rddata, error = 0, and in_op is ignored even if illegal.
- out_result and out_error hold stable while out_valid && !out_ready.
- Fields of an invalid stage are don't-care internally but are driven to 0 at the output when out_valid=0.

Optional Feature:
- Macro BMU_PIPE_PERF_CNT_EN.
- Defined: adds outputs perf_ops_cnt [31:0] and perf_err_cnt [31:0].
  - perf_ops_cnt increments on each out_valid && out_ready.
  - perf_err_cnt increments on each out_valid && out_ready && out_error.
  - Both counters wrap at 2^32, reset to 0, and use the same clk/rst.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package bmu_pipe_pkg holds:
  - the op enum bmu_op_e (4-bit, values above);
  - BMU_OP_ILLEGAL_MIN = 12;
  - a packed stage struct bmu_stage_t {valid, result[WIDTH], error}, parametrised via a localparam-width typedef in the module.
- One natural sub-module, bmu_alu_comb: purely combinational op decode and compute, WIDTH-parametrised, outputs {result, error}.
- bmu_pipe instantiates bmu_alu_comb plus the stage registers and the stall logic.

Test Plan:
- WIDTH=32, PIPE_STAGES=2: CLZ A=0x0000_0000 -> 32; CLZ A=0x0001_0000 -> 15; CPOP A=0xF0F0_0001 -> 9. Each appears exactly 2 cycles after acceptance.
- ROL A=0x8000_0001 B=0x0000_0021 (shamt 1) -> 0x0000_0003. BINV A=0 B=31 -> 0x8000_0000.
- in_op=12, A=0x1234 -> out_error=1, out_result=0. Following op ANDN A=0xFF00 B=0x0F00 -> 0xF000, error=0.
- CSR: in_csr_ren=1, rddata=0xDEAD_BEEF, in_op=13 -> result 0xDEAD_BEEF, error=0.
- Backpressure: stream 5 back-to-back ops with out_ready=0 for 3 cycles once out_valid rises.
  - in_ready drops in the same cycle; out_result holds stable.
  - All 5 results are delivered in order with no duplicates.
- Reset mid-flight: assert rst for 1 cycle with 2 ops in flight -> next cycle out_valid=0, out_result=0, in_ready=1; no stale result emerges afterward. With BMU_PIPE_PERF_CNT_EN, the counters read 0.
